// File: rtl/register_file_param_if.sv
// register_file_param_if: read/write port bundle between decode/write-back
// and the integer register file. A1/A2 come from rs1/rs2, A3/WD3/WE3 from
// the write-back stage, RD1/RD2/busy flow back to decode.
interface register_file_param_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 32
) ();
  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]   A1;
  logic [AW-1:0]   A2;
  logic [AW-1:0]   A3;
  logic [XLEN-1:0] WD3;
  logic            WE3;
  logic [XLEN-1:0] RD1;
  logic [XLEN-1:0] RD2;
  logic            busy;

  modport master (
    output A1, A2, A3, WD3, WE3,
    input  RD1, RD2, busy
  );

  modport slave (
    input  A1, A2, A3, WD3, WE3,
    output RD1, RD2, busy
  );
endinterface

// File: rtl/register_file_param.sv
// register_file_param: parameterised integer register file with two
// combinational read ports, one synchronous write port, optional hard-wired
// zero register, optional same-cycle write-to-read bypass and a post-reset
// clear sequencer that zeroes one register per cycle while raising busy.
module register_file_param #(
  parameter int XLEN           = 32,
  parameter int DEPTH          = 32,
  parameter bit ZERO_REG       = 1'b1,
  parameter bit BYPASS         = 1'b1,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input logic                  CLK,
  input logic                  rst,
  register_file_param_if.slave bus
);
  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  typedef enum logic {
    RUN   = 1'b0,
    CLEAR = 1'b1
  } state_e;

  state_e          state_r;
  state_e          state_next_s;
  logic [AW-1:0]   ptr_r;
  logic [AW-1:0]   ptr_next_s;
  logic            busy_r;
  logic            busy_s;
  logic            wr_ok_s;
  logic            mem_we_s;
  logic [AW-1:0]   mem_addr_s;
  logic [XLEN-1:0] mem_wd_s;
  logic [XLEN-1:0] regs_r [DEPTH];
  logic [XLEN-1:0] rd1_s;
  logic [XLEN-1:0] rd2_s;

  // Without the clear feature busy never rises, whatever state_r holds.
  assign busy_s = (CLEAR_ON_RESET == 1'b1) ? busy_r : 1'b0;

  // A write qualifies when enabled, not sweeping and not aimed at the zero
  // register. rst is deliberately absent here: it gates only the storage
  // write, so rst never reaches RD1/RD2 combinationally.
  assign wr_ok_s = bus.WE3 && !busy_s &&
                   !((ZERO_REG == 1'b1) && (bus.A3 == '0));

  // Clear-sweep next state: advance the pointer and return to RUN after the last index.
  always_comb begin
    state_next_s = state_r;
    ptr_next_s   = ptr_r;
    case (state_r)
      RUN: begin
        state_next_s = RUN;
        ptr_next_s   = ptr_r;
      end
      CLEAR: begin
        ptr_next_s = ptr_r + AW'(1);
        if (ptr_r == LAST_IDX) begin
          state_next_s = RUN;
        end else begin
          state_next_s = CLEAR;
        end
      end
      default: begin
        state_next_s = (CLEAR_ON_RESET == 1'b1) ? CLEAR : RUN;
        ptr_next_s   = '0;
      end
    endcase
  end

  // Sequencer registers; reset (re)starts the sweep at register 0.
  always_ff @(posedge CLK) begin
    if (rst) begin
      state_r <= (CLEAR_ON_RESET == 1'b1) ? CLEAR : RUN;
      ptr_r   <= '0;
      busy_r  <= CLEAR_ON_RESET;
    end else begin
      state_r <= state_next_s;
      ptr_r   <= ptr_next_s;
      busy_r  <= (CLEAR_ON_RESET == 1'b1) && (state_next_s == CLEAR);
    end
  end

  // Storage write port: nothing in reset, sweep clear while busy, else qualified writes.
  always_comb begin
    mem_we_s   = 1'b0;
    mem_addr_s = bus.A3;
    mem_wd_s   = bus.WD3;
    if (rst) begin
      mem_we_s = 1'b0;
    end else if (busy_s) begin
      mem_we_s   = 1'b1;
      mem_addr_s = ptr_r;
      mem_wd_s   = '0;
    end else if (wr_ok_s) begin
      mem_we_s = 1'b1;
    end else begin
      mem_we_s = 1'b0;
    end
  end

  // Register array update.
  always_ff @(posedge CLK) begin
    if (mem_we_s) begin
      regs_r[mem_addr_s] <= mem_wd_s;
    end
  end

  // Read port 1: busy and zero register force 0, then bypass, then storage.
  always_comb begin
    rd1_s = '0;
    if (busy_s) begin
      rd1_s = '0;
    end else if ((ZERO_REG == 1'b1) && (bus.A1 == '0)) begin
      rd1_s = '0;
    end else if ((BYPASS == 1'b1) && wr_ok_s && (bus.A3 == bus.A1)) begin
      rd1_s = bus.WD3;
    end else begin
      rd1_s = regs_r[bus.A1];
    end
  end

  // Read port 2: same priority as port 1.
  always_comb begin
    rd2_s = '0;
    if (busy_s) begin
      rd2_s = '0;
    end else if ((ZERO_REG == 1'b1) && (bus.A2 == '0)) begin
      rd2_s = '0;
    end else if ((BYPASS == 1'b1) && wr_ok_s && (bus.A3 == bus.A2)) begin
      rd2_s = bus.WD3;
    end else begin
      rd2_s = regs_r[bus.A2];
    end
  end

  assign bus.RD1  = rd1_s;
  assign bus.RD2  = rd2_s;
  assign bus.busy = busy_s;
endmodule

// File: tb/tb_register_file_param.sv
// tb_register_file_param: scoreboard bench for register_file_param.
// Four instances share clock and reset:
//   a: 32x32, zero reg, bypass, clear sweep
//   b: 32x32, no zero reg, no bypass, clear sweep
//   c: 64x16, zero reg, bypass, clear sweep
//   d: 32x8,  zero reg, bypass, no clear sweep
// Expectations are queued while stimulus is driven and drained/compared on
// the falling edge of the same cycle.
module tb_register_file_param;
  logic CLK = 1'b0;
  logic rst;

  always #5 CLK = ~CLK;

  register_file_param_if #(.XLEN(32), .DEPTH(32)) ifa ();
  register_file_param_if #(.XLEN(32), .DEPTH(32)) ifb ();
  register_file_param_if #(.XLEN(64), .DEPTH(16)) ifc ();
  register_file_param_if #(.XLEN(32), .DEPTH(8))  ifd ();

  register_file_param #(.XLEN(32), .DEPTH(32), .ZERO_REG(1'b1), .BYPASS(1'b1), .CLEAR_ON_RESET(1'b1))
    dut_a (.CLK(CLK), .rst(rst), .bus(ifa));
  register_file_param #(.XLEN(32), .DEPTH(32), .ZERO_REG(1'b0), .BYPASS(1'b0), .CLEAR_ON_RESET(1'b1))
    dut_b (.CLK(CLK), .rst(rst), .bus(ifb));
  register_file_param #(.XLEN(64), .DEPTH(16), .ZERO_REG(1'b1), .BYPASS(1'b1), .CLEAR_ON_RESET(1'b1))
    dut_c (.CLK(CLK), .rst(rst), .bus(ifc));
  register_file_param #(.XLEN(32), .DEPTH(8), .ZERO_REG(1'b1), .BYPASS(1'b1), .CLEAR_ON_RESET(1'b0))
    dut_d (.CLK(CLK), .rst(rst), .bus(ifd));

  localparam int S_ARD1 = 0;
  localparam int S_ARD2 = 1;
  localparam int S_ABSY = 2;
  localparam int S_BRD1 = 3;
  localparam int S_BRD2 = 4;
  localparam int S_BBSY = 5;
  localparam int S_CRD1 = 6;
  localparam int S_CRD2 = 7;
  localparam int S_CBSY = 8;
  localparam int S_DRD1 = 9;
  localparam int S_DBSY = 10;

  typedef struct {
    string       tag;
    int          sel;
    logic [63:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   check_cnt = 0;
  int   error_cnt = 0;

  // Single comparison point: counts and reports.
  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    check_cnt++;
    if (obs !== exp) begin
      error_cnt++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] obs_of(input int sel);
    logic [63:0] v;
    v = 64'h0;
    case (sel)
      S_ARD1:  v = 64'(ifa.RD1);
      S_ARD2:  v = 64'(ifa.RD2);
      S_ABSY:  v = 64'(ifa.busy);
      S_BRD1:  v = 64'(ifb.RD1);
      S_BRD2:  v = 64'(ifb.RD2);
      S_BBSY:  v = 64'(ifb.busy);
      S_CRD1:  v = ifc.RD1;
      S_CRD2:  v = ifc.RD2;
      S_CBSY:  v = 64'(ifc.busy);
      S_DRD1:  v = 64'(ifd.RD1);
      S_DBSY:  v = 64'(ifd.busy);
      default: v = 64'hxxxx_xxxx_xxxx_xxxx;
    endcase
    return v;
  endfunction

  task automatic expect_v(input string tag, input int sel, input logic [63:0] exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  // Sample at the falling edge, drain the scoreboard, then advance past the rising edge.
  task automatic step();
    exp_t e;
    @(negedge CLK);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_val(e.tag, obs_of(e.sel), e.exp);
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_all();
    ifa.WE3 = 1'b0; ifb.WE3 = 1'b0; ifc.WE3 = 1'b0; ifd.WE3 = 1'b0;
  endtask

  // Watchdog: the run is a few hundred cycles.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ifa.A1 = 5'd0; ifa.A2 = 5'd0; ifa.A3 = 5'd0; ifa.WD3 = 32'h0;
    ifb.A1 = 5'd0; ifb.A2 = 5'd0; ifb.A3 = 5'd0; ifb.WD3 = 32'h0;
    ifc.A1 = 4'd0; ifc.A2 = 4'd0; ifc.A3 = 4'd0; ifc.WD3 = 64'h0;
    ifd.A1 = 3'd0; ifd.A2 = 3'd0; ifd.A3 = 3'd0; ifd.WD3 = 32'h0;
    idle_all();
    rst = 1'b1;

    // Reset held for two edges: busy up on the sweeping instances only.
    @(posedge CLK);
    #1;
    expect_v("rst_busy_a", S_ABSY, 64'd1);
    expect_v("rst_busy_b", S_BBSY, 64'd1);
    expect_v("rst_busy_c", S_CBSY, 64'd1);
    expect_v("rst_busy_d", S_DBSY, 64'd0);
    expect_v("rst_rd1_a", S_ARD1, 64'd0);
    step();
    rst = 1'b0;

    // First sweep: write on cycle 1 dropped, reset re-asserted on cycle 10.
    // Instance d has no sweep and accepts writes at once; its reset-cycle write is dropped.
    for (int i = 0; i <= 10; i++) begin
      idle_all();
      ifa.A1 = 5'd3; ifa.A3 = 5'd3; ifa.WD3 = 32'h0000_1234; ifa.WE3 = (i == 1);
      ifd.A1 = 3'd7;
      if (i == 0) begin
        ifd.A3 = 3'd7; ifd.WD3 = 32'h0000_CAFE; ifd.WE3 = 1'b1;
      end else if (i == 2) begin
        ifd.A3 = 3'd2; ifd.WD3 = 32'h0000_0011; ifd.WE3 = 1'b1;
      end else if (i == 10) begin
        ifd.A3 = 3'd2; ifd.WD3 = 32'h0000_0055; ifd.WE3 = 1'b1;
        rst = 1'b1;
      end
      expect_v($sformatf("sweep1_busy_a[%0d]", i), S_ABSY, 64'd1);
      expect_v($sformatf("sweep1_busy_b[%0d]", i), S_BBSY, 64'd1);
      expect_v($sformatf("sweep1_busy_c[%0d]", i), S_CBSY, 64'd1);
      expect_v($sformatf("sweep1_rd1_a[%0d]", i), S_ARD1, 64'd0);
      expect_v($sformatf("nosweep_busy_d[%0d]", i), S_DBSY, 64'd0);
      expect_v($sformatf("nosweep_rd1_d[%0d]", i), S_DRD1, 64'h0000_CAFE);
      step();
    end
    rst = 1'b0;
    idle_all();

    // Restarted sweep: a/b busy exactly 32 cycles, c 16 cycles, reads 0 throughout.
    // b tries a write on its last busy cycle (dropped) and the first free cycle (taken).
    for (int i = 0; i < 32; i++) begin
      idle_all();
      ifa.A1 = 5'(i); ifa.A2 = 5'(31 - i);
      ifb.A1 = 5'(i); ifb.A2 = 5'(31 - i);
      ifc.A1 = 4'(i); ifc.A2 = 4'(15 - (i % 16));
      if (i == 31) begin
        ifb.A3 = 5'd12; ifb.WD3 = 32'h0000_AAAA; ifb.WE3 = 1'b1;
      end
      expect_v($sformatf("sweep2_busy_a[%0d]", i), S_ABSY, 64'd1);
      expect_v($sformatf("sweep2_busy_b[%0d]", i), S_BBSY, 64'd1);
      expect_v($sformatf("sweep2_busy_c[%0d]", i), S_CBSY, (i < 16) ? 64'd1 : 64'd0);
      expect_v($sformatf("sweep2_rd1_a[%0d]", i), S_ARD1, 64'd0);
      expect_v($sformatf("sweep2_rd2_a[%0d]", i), S_ARD2, 64'd0);
      expect_v($sformatf("sweep2_rd1_b[%0d]", i), S_BRD1, 64'd0);
      expect_v($sformatf("sweep2_rd2_b[%0d]", i), S_BRD2, 64'd0);
      expect_v($sformatf("sweep2_rd1_c[%0d]", i), S_CRD1, 64'd0);
      step();
    end
    idle_all();
    ifb.A3 = 5'd13; ifb.WD3 = 32'h0000_BBBB; ifb.WE3 = 1'b1;
    ifb.A1 = 5'd12;
    expect_v("sweep_done_busy_a", S_ABSY, 64'd0);
    expect_v("sweep_done_busy_b", S_BBSY, 64'd0);
    expect_v("sweep_done_busy_c", S_CBSY, 64'd0);
    expect_v("first_write_b_rd1", S_BRD1, 64'd0);
    step();
    idle_all();

    // Every register reads 0 after the sweep, except b[13] written on the first free cycle.
    for (int i = 0; i < 32; i++) begin
      ifa.A1 = 5'(i); ifa.A2 = 5'(31 - i);
      ifb.A1 = 5'(i); ifb.A2 = 5'(31 - i);
      ifc.A1 = 4'(i); ifc.A2 = 4'(15 - (i % 16));
      expect_v($sformatf("clear_rd1_a[%0d]", i), S_ARD1, 64'd0);
      expect_v($sformatf("clear_rd2_a[%0d]", i), S_ARD2, 64'd0);
      expect_v($sformatf("clear_rd1_b[%0d]", i), S_BRD1, (i == 13) ? 64'h0000_BBBB : 64'd0);
      expect_v($sformatf("clear_rd2_b[%0d]", i), S_BRD2, ((31 - i) == 13) ? 64'h0000_BBBB : 64'd0);
      expect_v($sformatf("clear_rd1_c[%0d]", i), S_CRD1, 64'd0);
      expect_v($sformatf("clear_rd2_c[%0d]", i), S_CRD2, 64'd0);
      step();
    end

    // d kept its contents through reset; its reset-cycle write to reg 2 was dropped.
    ifd.A1 = 3'd2; ifd.A2 = 3'd7;
    expect_v("nosweep_keep_d_r2", S_DRD1, 64'h0000_0011);
    step();

    // Write then read: reg 9 on a.
    ifa.A3 = 5'd9; ifa.WD3 = 32'h0000_0020; ifa.WE3 = 1'b1; ifa.A1 = 5'd9; ifa.A2 = 5'd1;
    expect_v("wr9_bypass_rd1_a", S_ARD1, 64'h0000_0020);
    expect_v("wr9_other_rd2_a", S_ARD2, 64'd0);
    step();
    idle_all();
    ifa.A1 = 5'd9; ifa.A2 = 5'd9;
    expect_v("wr9_rd1_a", S_ARD1, 64'h0000_0020);
    expect_v("wr9_rd2_a", S_ARD2, 64'h0000_0020);
    step();

    // Distinct data on two registers, read back on opposite ports.
    ifa.A3 = 5'd4; ifa.WD3 = 32'h4444_0004; ifa.WE3 = 1'b1;
    step();
    ifa.A3 = 5'd6; ifa.WD3 = 32'h6666_0006; ifa.WE3 = 1'b1;
    step();
    idle_all();
    ifa.A1 = 5'd6; ifa.A2 = 5'd4;
    expect_v("two_regs_rd1_a", S_ARD1, 64'h6666_0006);
    expect_v("two_regs_rd2_a", S_ARD2, 64'h4444_0004);
    step();

    // Bypass on a (same cycle) versus no bypass on b (old value, then new).
    ifa.A1 = 5'd5; ifa.A2 = 5'd5; ifa.A3 = 5'd5; ifa.WD3 = 32'hDEAD_BEEF; ifa.WE3 = 1'b1;
    ifb.A1 = 5'd5; ifb.A2 = 5'd5; ifb.A3 = 5'd5; ifb.WD3 = 32'hDEAD_BEEF; ifb.WE3 = 1'b1;
    expect_v("bypass_rd1_a", S_ARD1, 64'hDEAD_BEEF);
    expect_v("bypass_rd2_a", S_ARD2, 64'hDEAD_BEEF);
    expect_v("nobypass_rd1_b", S_BRD1, 64'd0);
    expect_v("nobypass_rd2_b", S_BRD2, 64'd0);
    step();
    idle_all();
    expect_v("bypass_next_rd1_a", S_ARD1, 64'hDEAD_BEEF);
    expect_v("nobypass_next_rd1_b", S_BRD1, 64'hDEAD_BEEF);
    expect_v("nobypass_next_rd2_b", S_BRD2, 64'hDEAD_BEEF);
    step();

    // Zero register: a ignores the write, b stores it.
    ifa.A1 = 5'd0; ifa.A2 = 5'd0; ifa.A3 = 5'd0; ifa.WD3 = 32'hFFFF_FFFF; ifa.WE3 = 1'b1;
    ifb.A1 = 5'd0; ifb.A2 = 5'd0; ifb.A3 = 5'd0; ifb.WD3 = 32'hFFFF_FFFF; ifb.WE3 = 1'b1;
    expect_v("zero_rd1_a", S_ARD1, 64'd0);
    expect_v("zero_rd2_a", S_ARD2, 64'd0);
    expect_v("nozero_same_rd1_b", S_BRD1, 64'd0);
    step();
    idle_all();
    expect_v("zero_next_rd1_a", S_ARD1, 64'd0);
    expect_v("nozero_next_rd1_b", S_BRD1, 64'hFFFF_FFFF);
    step();

    // 64-bit instance: full-width data through bypass and storage, top register.
    ifc.A1 = 4'd15; ifc.A2 = 4'd3; ifc.A3 = 4'd15; ifc.WD3 = 64'h0123_4567_89AB_CDEF; ifc.WE3 = 1'b1;
    expect_v("wide_bypass_rd1_c", S_CRD1, 64'h0123_4567_89AB_CDEF);
    expect_v("wide_other_rd2_c", S_CRD2, 64'd0);
    step();
    idle_all();
    ifc.A1 = 4'd15; ifc.A2 = 4'd15;
    expect_v("wide_rd1_c", S_CRD1, 64'h0123_4567_89AB_CDEF);
    expect_v("wide_rd2_c", S_CRD2, 64'h0123_4567_89AB_CDEF);
    step();

    check_val("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", check_cnt, error_cnt);
    $finish;
  end
endmodule
